// File: rtl/fabric_cfg_pkg.sv
// Shared types, header layout and header validation for the fabric
// configuration loader.
package fabric_cfg_pkg;

    localparam int CFG_WORD_W    = 16;
    localparam int HDR_START_MSB = 15;
    localparam int HDR_START_LSB = 8;
    localparam int HDR_COUNT_MSB = 7;
    localparam int HDR_COUNT_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    // Nine-bit sum so start_tile + count can never wrap into a legal range.
    function automatic logic header_is_legal(
        input logic [7:0] start_tile,
        input logic [7:0] count,
        input int         num_tiles
    );
        logic [8:0] limit;
        logic [8:0] span;
        limit = 9'(num_tiles);
        span  = {1'b0, start_tile} + {1'b0, count};
        return (count != 8'd0) && ({1'b0, start_tile} < limit) && (span <= limit);
    endfunction

endpackage

// File: rtl/tile_onehot_decoder.sv
// Turns a tile index plus an enable into the one-hot (or all-zero) strobe
// vector that drives the per-tile config_enable lines.
module tile_onehot_decoder #(
    parameter int NUM_TILES = 4,
    parameter int IDX_W     = 2
) (
    input  logic [IDX_W-1:0]     idx,
    input  logic                 enable,
    output logic [NUM_TILES-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int t = 0; t < NUM_TILES; t++) begin
            onehot[t] = enable && (idx == IDX_W'(t));
        end
    end

endmodule

// File: rtl/fabric_config_loader.sv
// Accepts a header word then N payload words and writes payload i to tile
// start_tile + i over the shared config bus, one registered strobe per word.
module fabric_config_loader
    import fabric_cfg_pkg::*;
#(
    parameter int NUM_TILES = 4,
    parameter int DATA_W    = CFG_WORD_W,
    parameter int IDX_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 abort,
    output logic [DATA_W-1:0]    config_data,
    output logic [NUM_TILES-1:0] config_enable,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [7:0]           remaining_q, remaining_d;
    logic [DATA_W-1:0]    config_data_q, config_data_d;
    logic [NUM_TILES-1:0] config_enable_q, config_enable_d;

    logic [7:0]           hdr_start;
    logic [7:0]           hdr_count;
    logic                 hdr_legal;
    logic                 accept;
    logic                 payload_accept;
    logic [NUM_TILES-1:0] tile_strobe;

    assign hdr_start      = in_data[HDR_START_MSB:HDR_START_LSB];
    assign hdr_count      = in_data[HDR_COUNT_MSB:HDR_COUNT_LSB];
    assign hdr_legal      = header_is_legal(hdr_start, hdr_count, NUM_TILES);
    assign accept         = in_valid & in_ready;
    assign payload_accept = accept && (state_q == LOAD);

    tile_onehot_decoder #(
        .NUM_TILES (NUM_TILES),
        .IDX_W     (IDX_W)
    ) u_decoder (
        .idx    (idx_q),
        .enable (payload_accept),
        .onehot (tile_strobe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        remaining_d = remaining_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hdr_legal) begin
                        state_d     = LOAD;
                        idx_d       = hdr_start[IDX_W-1:0];
                        remaining_d = hdr_count;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            LOAD: begin
                // Abort wins over any word presented in the same cycle.
                if (abort) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end else if (accept) begin
                    idx_d       = idx_q + IDX_W'(1);
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        error    = (state_q == ERR);
        unique case (state_q)
            IDLE:    in_ready = 1'b1;
            LOAD:    in_ready = !abort;
            default: in_ready = 1'b0;
        endcase
    end

    // Bus data is sticky between strobes; strobes last exactly one cycle.
    always_comb begin
        config_data_d   = payload_accept ? in_data : config_data_q;
        config_enable_d = tile_strobe;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            config_data_q   <= '0;
            config_enable_q <= '0;
        end else begin
            config_data_q   <= config_data_d;
            config_enable_q <= config_enable_d;
        end
    end

    assign config_data   = config_data_q;
    assign config_enable = config_enable_q;

endmodule

// File: tb/tb_fabric_config_loader.sv
// Self-checking bench: directed scenarios plus randomized loads, all checked
// per cycle against a transaction-level scoreboard of expected bus activity.
module tb_fabric_config_loader;

    localparam int NUM_TILES = 4;

    typedef struct {
        logic [NUM_TILES-1:0] en;
        logic [15:0]          data;
        logic                 done;
        logic                 err;
    } expT;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [15:0]          in_data;
    logic                 abort;
    logic [15:0]          config_data;
    logic [NUM_TILES-1:0] config_enable;
    logic                 busy;
    logic                 done;
    logic                 error;

    int    checkCount = 0;
    int    errorCount = 0;
    int    doneSeen   = 0;
    int    doneExp    = 0;
    int    pendingWords = 0;
    int    nextTile   = 0;
    logic [15:0] lastData = '0;
    logic  monitorOn  = 1'b0;
    expT   expQ[$];

    fabric_config_loader #(
        .NUM_TILES (NUM_TILES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .abort         (abort),
        .config_data   (config_data),
        .config_enable (config_enable),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: a header opens a load of count words onto consecutive
    // tiles; each payload word must appear on the bus the following cycle.
    task automatic modelAccept(input logic [15:0] w);
        int s;
        int c;
        expT e;
        if (pendingWords == 0) begin
            s = int'(w[15:8]);
            c = int'(w[7:0]);
            if (c > 0 && s + c <= NUM_TILES) begin
                pendingWords = c;
                nextTile     = s;
            end else begin
                e.en = '0; e.data = lastData; e.done = 1'b0; e.err = 1'b1;
                expQ.push_back(e);
            end
        end else begin
            lastData = w;
            e.en   = NUM_TILES'(1) << nextTile;
            e.data = w;
            e.done = (pendingWords == 1);
            e.err  = 1'b0;
            if (e.done) doneExp++;
            expQ.push_back(e);
            nextTile++;
            pendingWords--;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] w);
        logic got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            modelAccept(w);
        end else begin
            in_valid = 1'b0;
            checkOutput("readyTimeout", 32'd0, 32'd1);
        end
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic resetModel();
        expQ.delete();
        pendingWords = 0;
        nextTile     = 0;
        lastData     = '0;
    endtask

    always @(negedge clk) begin
        expT e;
        if (monitorOn) begin
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
            end else begin
                e.en = '0; e.data = lastData; e.done = 1'b0; e.err = 1'b0;
            end
            checkOutput("enable", 32'(config_enable), 32'(e.en));
            checkOutput("data", 32'(config_data), 32'(e.data));
            checkOutput("done", 32'(done), 32'(e.done));
            checkOutput("error", 32'(error), 32'(e.err));
            checkOutput("oneHot", 32'($countones(config_enable) <= 1), 32'd1);
            if (e.done || e.err) begin
                checkOutput("readyLow", 32'(in_ready), 32'd0);
                checkOutput("busyHigh", 32'(busy), 32'd1);
            end
            if (done) doneSeen++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        int c;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        abort    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstEnable", 32'(config_enable), 32'd0);
        checkOutput("rstData", 32'(config_data), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstError", 32'(error), 32'd0);
        checkOutput("rstReady", 32'(in_ready), 32'd1);
        rst       = 1'b0;
        monitorOn = 1'b1;

        // Full back-to-back load of all four tiles.
        applyStimulus(16'h0004);
        applyStimulus(16'hA001);
        applyStimulus(16'hA002);
        applyStimulus(16'hA003);
        applyStimulus(16'hA004);
        idleCycles(2);
        checkOutput("busyAfterLoad", 32'(busy), 32'd0);

        // Single word to tile 2 with valid gaps around it.
        idleCycles(2);
        applyStimulus(16'h0201);
        idleCycles(3);
        applyStimulus(16'h5555);
        idleCycles(3);

        // Illegal headers: zero count, start out of range, span overflow.
        applyStimulus(16'h0000);
        idleCycles(1);
        applyStimulus(16'h0400);
        idleCycles(1);
        applyStimulus(16'h0401);
        idleCycles(1);
        applyStimulus(16'h0303);
        idleCycles(2);
        checkOutput("busyAfterErr", 32'(busy), 32'd0);

        // Abort after one of three words; next word must be a header.
        applyStimulus(16'h0003);
        applyStimulus(16'h1111);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h2222;
        @(negedge clk);
        checkOutput("abortReady", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        pendingWords = 0;
        applyStimulus(16'h0101);
        applyStimulus(16'h7777);
        idleCycles(2);

        // Asynchronous reset in the middle of a load.
        applyStimulus(16'h0004);
        applyStimulus(16'hB001);
        applyStimulus(16'hB002);
        checkOutput("preRstEnable", 32'(config_enable), 32'h2);
        monitorOn = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstEnable", 32'(config_enable), 32'd0);
        checkOutput("asyncRstBusy", 32'(busy), 32'd0);
        checkOutput("asyncRstData", 32'(config_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
        monitorOn = 1'b1;
        applyStimulus(16'h0004);
        applyStimulus(16'hC001);
        applyStimulus(16'hC002);
        applyStimulus(16'hC003);
        applyStimulus(16'hC004);
        idleCycles(2);

        // Randomized legal and edge-case headers with random valid gaps.
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                s = int'($urandom_range(0, 6));
                c = int'($urandom_range(0, 6));
            end else begin
                s = int'($urandom_range(0, NUM_TILES - 1));
                c = int'($urandom_range(1, NUM_TILES - s));
            end
            applyStimulus({s[7:0], c[7:0]});
            while (pendingWords > 0) begin
                idleCycles(int'($urandom_range(0, 2)));
                applyStimulus(16'($urandom));
            end
            idleCycles(int'($urandom_range(0, 2)));
        end
        idleCycles(3);

        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        checkOutput("doneCount", 32'(doneSeen), 32'(doneExp));
        checkOutput("busyFinal", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
